intra_util_r: RTL and testbench
===============================

INTRA_UTIL_R -- requirements
Module: intra_util_r

Interface
REQ-001 Parameter NBANK, default 8, number of neighbour line-buffer SRAM banks (power of two).
REQ-002 Parameter NUNIT, default 16, number of 4-sample units per CTU edge for availability flags.
REQ-003 clk  input  1  clock; all state changes on its rising edge.
REQ-004 arst_n  input  1  reset, asynchronous, active-low.
REQ-005 rst_n  input  1  synchronous soft clear, active-low.
REQ-006 bStop  input  1  pipeline stall; freezes all state and outputs.
REQ-007 start  input  1  one-cycle request to fetch neighbours of one TU.
REQ-008 xTb, yTb  input  13 each  TU luma position.
REQ-009 tuSize  input  3  log2 of the TU size N, legal 2..5.
REQ-010 nMaxCUlog2  input  3  log2 of the CTU size, legal 4..6.
REQ-011 horFlag, verFlag  input  16 each  per-unit availability flags, top row and left column, within the CTU.
REQ-012 busy  output  1  fetch in progress.
REQ-013 rd_valid  output  1  read command valid this cycle.
REQ-014 rd_kind  output  2  command type: 0 = top-left, 1 = top, 2 = left.
REQ-015 rd_en  output  NBANK  one-hot bank read enable; all zero for top-left or unavailable units.
REQ-016 rd_idx  output  4  unit index k within the current phase.
REQ-017 rd_avail  output  1  unit is available.
REQ-018 tl_en  output  1  top-left SRAM read enable.
REQ-019 tl_rel  output  5  signed top-left relative address.
REQ-020 tl_rowA  output  1  TU top edge is on a CTU boundary; top data comes from the line zone.
REQ-021 done  output  1  one-cycle pulse issued with the last command.

Function
REQ-022 The block SHALL use a four-state FSM: IDLE, TL, TOP, LEFT.
REQ-023 In IDLE with start=1 and bStop=0, it SHALL latch xc=xTb%2^nMaxCUlog2, yc=yTb%2^nMaxCUlog2, N=1<<tuSize and the flags, then enter TL.
REQ-024 Start SHALL be ignored while busy; busy=1 in TL, TOP and LEFT.
REQ-025 TL SHALL last one cycle with: rd_valid=1, rd_kind=0, tl_en=1, tl_rel=(xc>>2)-(yc>>2) truncated to 5 bits, tl_rowA=(yc==0), rd_avail=1.
REQ-026 TOP SHALL last N/2 cycles with k=0..N/2-1; x4=(xc>>2)+k; rd_en bit x4%NBANK set only when rd_avail; rd_avail=(x4<NUNIT && horFlag[x4]).
REQ-027 LEFT SHALL last N/2 cycles with k=0..N/2-1; y4=(yc>>2)+k; bank=(NBANK-1)-(y4%NBANK); rd_avail=(y4<NUNIT && verFlag[y4]).
REQ-028 All command outputs SHALL be registered; the first command appears the cycle after start is accepted.
REQ-029 A fetch SHALL issue exactly 1+N commands.
REQ-030 done=1 SHALL accompany the last LEFT command, after which the FSM returns to IDLE; back-to-back start is accepted in the following cycle.
REQ-031 With bStop=1, state, counter and outputs SHALL hold, and an asserted rd_valid SHALL repeat unchanged.
REQ-032 x4 and y4 SHALL be computed 5 bits wide; units with index >= NUNIT are unavailable and must not alias.
REQ-033 rd_en, tl_en and done SHALL be 0 whenever rd_valid=0.

Reset
REQ-034 arst_n=0 or rst_n=0 SHALL force IDLE, clear the counter and latched fields, and drive every output to 0, including in the middle of a fetch.
REQ-035 rst_n SHALL take priority over bStop.

Structure
REQ-036 The state encoding, the rd_kind codes and NBANK/NUNIT SHALL live in a shared package, intra_pkg, together with the write-side zone codes.
REQ-037 One sub-module, intra_nb_bank_map, SHALL be combinational and map a unit index plus edge to a bank one-hot; the writer SHALL reuse it.

Verification
REQ-038 xTb=8, yTb=4, tuSize=2, nMaxCUlog2=6, flags all 1 -> 5 commands: TL tl_rel=1, tl_rowA=0; TOP banks 2,3; LEFT banks 6,5; done on cycle 5.
REQ-039 xTb=64, yTb=128, tuSize=5, nMaxCUlog2=6, horFlag=0x00FF -> tl_rowA=1, tl_rel=0; TOP k=0..7 avail with banks 0..7; k=8..15 rd_avail=0 and rd_en=0; 33 commands total.
REQ-040 xTb=48, yTb=0, tuSize=4, nMaxCUlog2=6 -> TOP k=4..7 give x4=16..19, unavailable, no aliasing to horFlag[0..3].
REQ-041 bStop held high for 3 cycles during TOP k=2 -> k=2 command repeats for 3 cycles, total command count unchanged.
REQ-042 arst_n pulsed during LEFT, then start -> outputs 0 immediately, and the new fetch begins cleanly with TL.
REQ-043 start asserted while busy, then again on the cycle after done -> first start ignored, second accepted.

Source files
------------

// File: rtl/intra_pkg.sv
// Shared types for the intra neighbour fetch/write path:
// FSM states, command kinds, bank sides, zone codes, defaults.
package intra_pkg;

  localparam int NBANK_DEF = 8;
  localparam int NUNIT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_TL   = 2'd1,
    ST_TOP  = 2'd2,
    ST_LEFT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    KIND_TL   = 2'd0,
    KIND_TOP  = 2'd1,
    KIND_LEFT = 2'd2
  } kind_e;

  typedef enum logic {
    SIDE_TOP  = 1'b0,
    SIDE_LEFT = 1'b1
  } side_e;

  // Write-side destinations of reconstructed samples.
  typedef enum logic [1:0] {
    ZONE_CTU  = 2'd0,
    ZONE_LINE = 2'd1,
    ZONE_TL   = 2'd2
  } zone_e;

  // 4-sample unit index, 5 bits so that
  // units past the CTU edge never wrap.
  function automatic logic [4:0] unit4(
    input logic [5:0] pos,
    input logic [3:0] k
  );
    return {1'b0, pos[5:2]} + {1'b0, k};
  endfunction

  // Index of the last unit of an N/2-long phase.
  function automatic logic [3:0] last_k(
    input logic [2:0] tu
  );
    logic [4:0] half;
    half = 5'd1 << (tu - 3'd1);
    return 4'(half - 5'd1);
  endfunction

endpackage

// File: rtl/intra_nb_bank_map.sv
// Maps a unit index and edge side to a one-hot bank select.
// unit_i: unit index, side_i: top/left, onehot_o: bank one-hot.
module intra_nb_bank_map
  import intra_pkg::*;
#(
  parameter int NBANK = NBANK_DEF
) (
  input  logic [4:0]       unit_i,
  input  side_e            side_i,
  output logic [NBANK-1:0] onehot_o
);

  localparam int BW = $clog2(NBANK);

  logic [BW-1:0] bank;

  // Left column runs banks in reverse:
  // (NBANK-1)-(u%NBANK) is the bitwise
  // complement of the low bits.
  always_comb begin
    bank = unit_i[BW-1:0];
    if (side_i == SIDE_LEFT) begin
      bank = ~unit_i[BW-1:0];
    end
    onehot_o       = '0;
    onehot_o[bank] = 1'b1;
  end

endmodule

// File: rtl/intra_util_r.sv
// Neighbour read sequencer for one TU: TL, N/2 top, N/2 left.
// In: start/TU geometry/flags, bStop, resets. Out: read command.
module intra_util_r
  import intra_pkg::*;
#(
  parameter int NBANK = NBANK_DEF,
  parameter int NUNIT = NUNIT_DEF
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             rst_n,
  input  logic             bStop,
  input  logic             start,
  input  logic [12:0]      xTb,
  input  logic [12:0]      yTb,
  input  logic [2:0]       tuSize,
  input  logic [2:0]       nMaxCUlog2,
  input  logic [NUNIT-1:0] horFlag,
  input  logic [NUNIT-1:0] verFlag,
  output logic             busy,
  output logic             rd_valid,
  output logic [1:0]       rd_kind,
  output logic [NBANK-1:0] rd_en,
  output logic [3:0]       rd_idx,
  output logic             rd_avail,
  output logic             tl_en,
  output logic [4:0]       tl_rel,
  output logic             tl_rowA,
  output logic             done
);

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [5:0]       xc_q, xc_d;
  logic [5:0]       yc_q, yc_d;
  logic [2:0]       tu_q, tu_d;
  logic [NUNIT-1:0] hor_q, hor_d;
  logic [NUNIT-1:0] ver_q, ver_d;

  logic             valid_q, valid_d;
  logic [1:0]       kind_q, kind_d;
  logic [NBANK-1:0] en_q, en_d;
  logic [3:0]       idx_q, idx_d;
  logic             avail_q, avail_d;
  logic             tlen_q, tlen_d;
  logic [4:0]       rel_q, rel_d;
  logic             rowa_q, rowa_d;
  logic             done_q, done_d;

  logic [5:0]       cu_mask;
  logic             last;
  logic [4:0]       u4;
  side_e            side;
  logic [NUNIT-1:0] flg_sh;
  logic             u_avail;
  logic [NBANK-1:0] bank_oh;

  assign cu_mask = 6'((7'd1 << nMaxCUlog2) - 7'd1);
  assign last    = (cnt_q == last_k(tu_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    xc_d    = xc_q;
    yc_d    = yc_q;
    tu_d    = tu_q;
    hor_d   = hor_q;
    ver_d   = ver_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_TL;
          cnt_d   = '0;
          xc_d    = xTb[5:0] & cu_mask;
          yc_d    = yTb[5:0] & cu_mask;
          tu_d    = tuSize;
          hor_d   = horFlag;
          ver_d   = verFlag;
        end
      end
      ST_TL: begin
        state_d = ST_TOP;
        cnt_d   = '0;
      end
      ST_TOP: begin
        if (last) begin
          state_d = ST_LEFT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      ST_LEFT: begin
        if (last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (bStop) begin
      state_d = state_q;
      cnt_d   = cnt_q;
      xc_d    = xc_q;
      yc_d    = yc_q;
      tu_d    = tu_q;
      hor_d   = hor_q;
      ver_d   = ver_q;
    end
    if (!rst_n) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      xc_d    = '0;
      yc_d    = '0;
      tu_d    = '0;
      hor_d   = '0;
      ver_d   = '0;
    end
  end

  // The command register always reflects the
  // next state, so a held state repeats it.
  always_comb begin
    side   = (state_d == ST_LEFT) ? SIDE_LEFT
                                  : SIDE_TOP;
    u4     = (side == SIDE_LEFT) ? unit4(yc_d, cnt_d)
                                 : unit4(xc_d, cnt_d);
    flg_sh = (side == SIDE_LEFT) ? (ver_d >> u4)
                                 : (hor_d >> u4);
    u_avail = (int'(u4) < NUNIT) && flg_sh[0];
  end

  intra_nb_bank_map #(
    .NBANK(NBANK)
  ) u_map (
    .unit_i  (u4),
    .side_i  (side),
    .onehot_o(bank_oh)
  );

  always_comb begin
    valid_d = 1'b0;
    kind_d  = '0;
    en_d    = '0;
    idx_d   = '0;
    avail_d = 1'b0;
    tlen_d  = 1'b0;
    rel_d   = '0;
    rowa_d  = 1'b0;
    done_d  = 1'b0;
    unique case (state_d)
      ST_TL: begin
        valid_d = 1'b1;
        kind_d  = KIND_TL;
        avail_d = 1'b1;
        tlen_d  = 1'b1;
        rel_d   = {1'b0, xc_d[5:2]}
                - {1'b0, yc_d[5:2]};
        rowa_d  = (yc_d == '0);
      end
      ST_TOP, ST_LEFT: begin
        valid_d = 1'b1;
        kind_d  = (state_d == ST_LEFT) ? KIND_LEFT
                                       : KIND_TOP;
        idx_d   = cnt_d;
        avail_d = u_avail;
        en_d    = u_avail ? bank_oh : '0;
        done_d  = (state_d == ST_LEFT)
               && (cnt_d == last_k(tu_d));
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      xc_q    <= '0;
      yc_q    <= '0;
      tu_q    <= '0;
      hor_q   <= '0;
      ver_q   <= '0;
      valid_q <= 1'b0;
      kind_q  <= '0;
      en_q    <= '0;
      idx_q   <= '0;
      avail_q <= 1'b0;
      tlen_q  <= 1'b0;
      rel_q   <= '0;
      rowa_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      xc_q    <= xc_d;
      yc_q    <= yc_d;
      tu_q    <= tu_d;
      hor_q   <= hor_d;
      ver_q   <= ver_d;
      valid_q <= valid_d;
      kind_q  <= kind_d;
      en_q    <= en_d;
      idx_q   <= idx_d;
      avail_q <= avail_d;
      tlen_q  <= tlen_d;
      rel_q   <= rel_d;
      rowa_q  <= rowa_d;
      done_q  <= done_d;
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign rd_valid = valid_q;
  assign rd_kind  = kind_q;
  assign rd_en    = en_q;
  assign rd_idx   = idx_q;
  assign rd_avail = avail_q;
  assign tl_en    = tlen_q;
  assign tl_rel   = rel_q;
  assign tl_rowA  = rowa_q;
  assign done     = done_q;

endmodule

// File: tb/tb_intra_util_r.sv
// Testbench for intra_util_r: queue-based command model,
// per-cycle compare, directed literal checks, random traffic.
module tb_intra_util_r;

  logic        clk = 1'b0;
  logic        arst_n, rst_n, bStop, start;
  logic [12:0] xTb, yTb;
  logic [2:0]  tuSize, nMaxCUlog2;
  logic [15:0] horFlag, verFlag;
  logic        busy, rd_valid, rd_avail;
  logic        tl_en, tl_rowA, done;
  logic [1:0]  rd_kind;
  logic [7:0]  rd_en;
  logic [3:0]  rd_idx;
  logic [4:0]  tl_rel;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  intra_util_r dut (
    .clk       (clk),
    .arst_n    (arst_n),
    .rst_n     (rst_n),
    .bStop     (bStop),
    .start     (start),
    .xTb       (xTb),
    .yTb       (yTb),
    .tuSize    (tuSize),
    .nMaxCUlog2(nMaxCUlog2),
    .horFlag   (horFlag),
    .verFlag   (verFlag),
    .busy      (busy),
    .rd_valid  (rd_valid),
    .rd_kind   (rd_kind),
    .rd_en     (rd_en),
    .rd_idx    (rd_idx),
    .rd_avail  (rd_avail),
    .tl_en     (tl_en),
    .tl_rel    (tl_rel),
    .tl_rowA   (tl_rowA),
    .done      (done)
  );

  typedef struct packed {
    logic       busy;
    logic       valid;
    logic [1:0] kind;
    logic [7:0] en;
    logic [3:0] idx;
    logic       avail;
    logic       tl_en;
    logic [4:0] rel;
    logic       rowa;
    logic       done;
  } cmd_t;

  cmd_t q[$];
  cmd_t cur;

  // Full command list of one fetch, from the TU geometry.
  function automatic void gen(
    input int x, input int y, input int tu,
    input int nm, input logic [15:0] h,
    input logic [15:0] v
  );
    int xc, yc, half, u;
    cmd_t c;
    xc   = x % (1 << nm);
    yc   = y % (1 << nm);
    half = (1 << tu) / 2;
    c = '0;
    c.busy = 1; c.valid = 1; c.kind = 0;
    c.avail = 1; c.tl_en = 1;
    c.rel  = 5'((xc / 4) - (yc / 4));
    c.rowa = (yc == 0);
    q.push_back(c);
    for (int k = 0; k < half; k++) begin
      u = xc / 4 + k;
      c = '0;
      c.busy = 1; c.valid = 1; c.kind = 1;
      c.idx = 4'(k);
      c.avail = (u < 16) ? h[u % 16] : 1'b0;
      c.en = c.avail ? 8'(1 << (u % 8)) : 8'h0;
      q.push_back(c);
    end
    for (int k = 0; k < half; k++) begin
      u = yc / 4 + k;
      c = '0;
      c.busy = 1; c.valid = 1; c.kind = 2;
      c.idx = 4'(k);
      c.avail = (u < 16) ? v[u % 16] : 1'b0;
      c.en = c.avail ? 8'(1 << (7 - (u % 8))) : 8'h0;
      c.done = (k == half - 1);
      q.push_back(c);
    end
  endfunction

  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      q.delete();
      cur = '0;
    end else if (!rst_n) begin
      q.delete();
      cur = '0;
    end else if (!bStop) begin
      if (q.size() > 0) begin
        cur = q.pop_front();
      end else if (cur.valid) begin
        cur = '0;
      end else if (start) begin
        gen(int'(xTb), int'(yTb), int'(tuSize),
            int'(nMaxCUlog2), horFlag, verFlag);
        cur = q.pop_front();
      end
    end
  end

  task automatic cmp();
    cmd_t act;
    act = {busy, rd_valid, rd_kind, rd_en, rd_idx,
           rd_avail, tl_en, tl_rel, tl_rowA, done};
    checks++;
    if (act !== cur) begin
      failures++;
      $display("FAIL cycle_cmp t=%0t act=%h exp=%h",
               $time, act, cur);
    end
  endtask

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
    cmp();
  endtask

  task automatic setup(input int x, input int y,
                       input int tu, input int nm,
                       input logic [15:0] h,
                       input logic [15:0] v);
    xTb = 13'(x); yTb = 13'(y);
    tuSize = 3'(tu); nMaxCUlog2 = 3'(nm);
    horFlag = h; verFlag = v;
  endtask

  int n;

  initial begin
    arst_n = 0; rst_n = 1; bStop = 0; start = 0;
    setup(0, 0, 2, 6, 16'h0, 16'h0);
    cur = '0;
    cyc();
    cyc();
    chk("rst_busy", busy, 0);
    chk("rst_valid", rd_valid, 0);
    arst_n = 1;
    cyc();

    // Small TU, all units available
    setup(8, 4, 2, 6, 16'hFFFF, 16'hFFFF);
    start = 1;
    cyc();
    start = 0;
    chk("t1_kind", rd_kind, 0);
    chk("t1_tlen", tl_en, 1);
    chk("t1_rel", tl_rel, 1);
    chk("t1_rowa", tl_rowA, 0);
    cyc(); chk("t1_top0", rd_en, 8'h04);
    cyc(); chk("t1_top1", rd_en, 8'h08);
    cyc(); chk("t1_left0", rd_en, 8'h40);
    cyc(); chk("t1_left1", rd_en, 8'h20);
    chk("t1_done", done, 1);
    cyc(); chk("t1_idle", rd_valid, 0);

    // 32x32 TU on CTU corner, half the top row available
    setup(64, 128, 5, 6, 16'h00FF, 16'hFFFF);
    start = 1;
    cyc();
    start = 0;
    chk("t2_rowa", tl_rowA, 1);
    chk("t2_rel", tl_rel, 0);
    n = 1;
    for (int k = 0; k < 32; k++) begin
      cyc();
      if (rd_valid) n++;
      if (k == 7) chk("t2_k7_en", rd_en, 8'h80);
      if (k == 8) chk("t2_k8_av", rd_avail, 0);
      if (k == 8) chk("t2_k8_en", rd_en, 0);
      if (k == 31) chk("t2_done", done, 1);
    end
    chk("t2_count", n, 33);
    cyc();

    // Top units past the CTU edge
    setup(48, 0, 4, 6, 16'hFFFF, 16'hFFFF);
    start = 1;
    cyc();
    start = 0;
    for (int k = 0; k < 16; k++) begin
      cyc();
      if (k == 4) chk("t3_k4_idx", rd_idx, 4);
      if (k == 4) chk("t3_k4_av", rd_avail, 0);
      if (k == 4) chk("t3_k4_en", rd_en, 0);
    end
    cyc();

    // Stall during TOP k=2
    setup(0, 0, 3, 4, 16'hFFFF, 16'hFFFF);
    start = 1;
    cyc();
    start = 0;
    cyc(); cyc(); cyc();
    chk("t4_k2", rd_idx, 2);
    bStop = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t4_hold_idx", rd_idx, 2);
      chk("t4_hold_v", rd_valid, 1);
    end
    bStop = 0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (rd_valid) n++;
      if (done) break;
    end
    chk("t4_rest", n, 5);
    cyc();

    // Async reset in LEFT, then a clean restart
    setup(0, 0, 3, 6, 16'hFFFF, 16'hFFFF);
    start = 1;
    cyc();
    start = 0;
    repeat (6) cyc();
    chk("t5_inleft", rd_kind, 2);
    arst_n = 0;
    #1;
    chk("t5_valid0", rd_valid, 0);
    chk("t5_busy0", busy, 0);
    chk("t5_en0", rd_en, 0);
    cyc();
    arst_n = 1;
    cyc();
    start = 1;
    cyc();
    start = 0;
    chk("t5_tl", {rd_valid, rd_kind, tl_en}, 4'b1001);
    repeat (9) cyc();

    // Start while busy ignored; start after done accepted
    setup(4, 8, 2, 6, 16'hFFFF, 16'hFFFF);
    start = 1;
    cyc();
    start = 0;
    cyc();
    start = 1;
    cyc();
    start = 0;
    chk("t6_nostart", rd_kind, 1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      if (done) break;
      cyc();
      n++;
    end
    chk("t6_done", done, 1);
    cyc();
    chk("t6_idle", busy, 0);
    start = 1;
    cyc();
    start = 0;
    chk("t6_restart", {rd_valid, rd_kind}, 3'b100);
    repeat (6) cyc();

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      start = ($urandom % 3 == 0);
      xTb = 13'($urandom);
      yTb = 13'($urandom);
      tuSize = 3'($urandom_range(5, 2));
      nMaxCUlog2 = 3'($urandom_range(6, 4));
      horFlag = 16'($urandom);
      verFlag = 16'($urandom);
      bStop = ($urandom % 8 == 0);
      rst_n = !($urandom % 60 == 0);
      cyc();
    end
    start = 0; bStop = 0; rst_n = 1;
    repeat (40) cyc();

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
